life_sequencer: RTL and testbench

// Run/pause/step controller for the NxN Conway grid. Debounces the two board buttons and runs a
// RUN/PAUSED/STEP/LOAD state machine. Drives the cell enable and cell reload strobes, plus the LED

---
 rtl/life_sequencer.sv | 136 +++++++++++++
 tb/tb_life_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// Run/pause/step controller for the Conway cell array: button debounce, LOAD/RUN/PAUSED/STEP FSM,
// generation counter and LED column scan. Define STALL_DETECT_EN to pause automatically on a static grid.
module life_sequencer #(
    parameter int N               = 5,
    parameter int GAME_DIVIDER    = 22,
    parameter int DISPLAY_DIVIDER = 14,
    parameter int DEBOUNCE_BITS   = 16,
    parameter int GEN_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_run,
    input  logic                 btn_step,
    input  logic [N*N-1:0]       cells,
    output logic                 cell_ena,
    output logic                 cell_load,
    output logic [$clog2(N):0]   x,
    output logic                 running,
    output logic [GEN_W-1:0]     generation,
    output logic                 stalled
);
    localparam int XW = $clog2(N) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(N - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_PAUSED, S_STEP} state_t;

    state_t                     state, next_state;
    logic [GAME_DIVIDER-1:0]    tick;
    logic [DISPLAY_DIVIDER-1:0] dwell;
    logic [1:0]                 sync1, sync2, level, level_d;
    logic [DEBOUNCE_BITS-1:0]   db_cnt [2];
    logic                       run_ev, step_ev, both_ev, stall_hit;

    // Bit 0 = run button, bit 1 = step button. The counter restarts whenever the
    // synchronised input falls back to the registered level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= {btn_step, btn_run};
            sync2   <= sync1;
            level_d <= level;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == '1) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DEBOUNCE_BITS'(1);
                end
            end
        end
    end

    assign run_ev  = level[0] & ~level_d[0];
    assign step_ev = level[1] & ~level_d[1];
    assign both_ev = run_ev & step_ev;

    always_comb begin
        next_state = state;
        cell_ena   = 1'b0;
        case (state)
            S_LOAD:   next_state = S_RUN;
            S_RUN: begin
                cell_ena = (tick == '1);
                if (both_ev)     next_state = S_LOAD;
                else if (run_ev) next_state = S_PAUSED;
            end
            S_PAUSED: begin
                if (both_ev)      next_state = S_LOAD;
                else if (run_ev)  next_state = S_RUN;
                else if (step_ev) next_state = S_STEP;
            end
            S_STEP: begin
                cell_ena   = 1'b1;
                next_state = both_ev ? S_LOAD : S_PAUSED;
            end
            default:  next_state = S_LOAD;
        endcase
        if (stall_hit && next_state != S_LOAD) next_state = S_PAUSED;
        // Reset kills the strobe in the very cycle it is asserted.
        if (!rst) cell_ena = 1'b0;
        cell_load = !rst || (state == S_LOAD);
        running   = (state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_LOAD;
            tick       <= '0;
            dwell      <= '0;
            x          <= '0;
            generation <= '0;
        end else begin
            state <= next_state;
            tick  <= (state == S_RUN && next_state == S_RUN) ? tick + GAME_DIVIDER'(1) : '0;
            dwell <= dwell + DISPLAY_DIVIDER'(1);
            if (dwell == '1) x <= (x == X_LAST) ? '0 : x + XW'(1);
            if (state == S_LOAD)  generation <= '0;
            else if (cell_ena)    generation <= generation + GEN_W'(1);
        end
    end

`ifdef STALL_DETECT_EN
    logic [N*N-1:0] prev;
    logic           check;

    // One cycle after the strobe the cells hold the new generation; compare it to the snapshot.
    assign stall_hit = check && (cells == prev);

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev    <= '0;
            check   <= 1'b0;
            stalled <= 1'b0;
        end else begin
            check <= cell_ena;
            if (cell_ena) prev <= cells;
            if (stall_hit)                     stalled <= 1'b1;
            else if (state == S_LOAD || run_ev) stalled <= 1'b0;
        end
    end
`else
    logic unused_cells;

    assign unused_cells = ^cells;
    assign stall_hit    = 1'b0;
    assign stalled      = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer with small dividers: a cycle table after reset
// followed by directed pause/step/bounce/reload/wrap/reset/stall sequences.
module tb_life_sequencer;
    localparam int N = 5;
    localparam logic [24:0] BLOCK = 25'h00018C0;

    logic        clk, rst, btn_run, btn_step;
    logic [24:0] cells;
    logic        cell_ena, cell_load, running, stalled;
    logic [3:0]  x;
    logic [3:0]  generation;
    logic        hold_cells;

    int n_checks = 0;
    int n_fail   = 0;

    life_sequencer #(
        .N(N), .GAME_DIVIDER(3), .DISPLAY_DIVIDER(2), .DEBOUNCE_BITS(2), .GEN_W(4)
    ) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step), .cells(cells),
        .cell_ena(cell_ena), .cell_load(cell_load), .x(x), .running(running),
        .generation(generation), .stalled(stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       b_run;
        logic       b_step;
        logic       ena;
        logic       load;
        logic       run;
        logic [3:0] x;
        logic [3:0] gen;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input logic br, input logic ena, input logic load,
                                input logic run, input logic [3:0] xx, input logic [3:0] gg);
        vec_t v;
        v.b_run = br; v.b_step = 1'b0; v.ena = ena; v.load = load; v.run = run;
        v.x = xx; v.gen = gg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Cells toggle every cycle so the stall comparison never matches unless held.
    task automatic next_cycle();
        @(posedge clk);
        #2;
        if (hold_cells) cells = BLOCK;
        else            cells = ~cells;
    endtask

    task automatic settle(input int n);
        repeat (n) next_cycle();
    endtask

    int lat, k, n_ena, n_load, ran;
    logic [3:0] g;
    logic found;

    initial begin
        vecs[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 1; i <= 3; i++)   vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        for (int i = 4; i <= 7; i++)   vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
        vecs[8] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0);
        vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
        for (int i = 10; i <= 11; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1);
        for (int i = 12; i <= 15; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd1);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 4'd1);
        for (int i = 17; i <= 19; i++) vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2);
        for (int i = 20; i <= 22; i++) vecs[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2);

        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        cells = 25'h1555555; hold_cells = 1'b0;
        settle(3);
        check("reset_load", cell_load, 1);
        check("reset_ena", cell_ena, 0);
        check("reset_running", running, 0);
        check("reset_x", x, 0);
        check("reset_gen", generation, 0);
        check("reset_stalled", stalled, 0);

        // Table: LOAD, RUN cadence, x scan, then a run press that pauses.
        rst = 1'b1;
        #1;
        for (int i = 0; i < 23; i++) begin
            if (i > 0) next_cycle();
            btn_run  = vecs[i].b_run;
            btn_step = vecs[i].b_step;
            #1;
            check($sformatf("vec%0d", i), {cell_ena, cell_load, running, x, generation},
                  {vecs[i].ena, vecs[i].load, vecs[i].run, vecs[i].x, vecs[i].gen});
        end

        // Paused: no strobes.
        n_ena = 0;
        for (int i = 0; i < 20; i++) begin next_cycle(); n_ena += int'(cell_ena); end
        check("paused_no_ena", n_ena, 0);
        check("paused_gen", generation, 2);

        // Resume: 7-cycle press latency, first strobe on the 8th RUN cycle.
        btn_run = 1'b1;
        lat = 0;
        while (!running && lat < 12) begin next_cycle(); lat++; end
        check("resume_latency", lat, 7);
        k = 1;
        while (!cell_ena && k < 20) begin next_cycle(); k++; end
        check("resume_first_ena", k, 8);
        next_cycle();
        check("resume_gen", generation, 3);
        btn_run = 1'b0;
        settle(10);

        btn_run = 1'b1;
        lat = 0;
        while (running && lat < 12) begin next_cycle(); lat++; end
        check("pause_latency", lat, 7);
        btn_run = 1'b0;
        settle(10);

        // Single step from PAUSED.
        g = generation;
        btn_step = 1'b1; n_ena = 0; ran = 0;
        for (int i = 0; i < 26; i++) begin
            next_cycle();
            if (i == 8) btn_step = 1'b0;
            n_ena += int'(cell_ena);
            ran   |= int'(running);
        end
        check("step_one_ena", n_ena, 1);
        check("step_gen", generation, 32'(g + 4'd1));
        check("step_not_running", ran, 0);

        // Bounce 1-0-1 on step: filtered out.
        g = generation;
        btn_step = 1'b1; next_cycle();
        btn_step = 1'b0; next_cycle();
        btn_step = 1'b1; next_cycle();
        btn_step = 1'b0;
        n_ena = 0;
        for (int i = 0; i < 12; i++) begin next_cycle(); n_ena += int'(cell_ena); end
        check("bounce_no_ena", n_ena, 0);
        check("bounce_gen", generation, 32'(g));

        // Both buttons together: reload.
        btn_run = 1'b1; btn_step = 1'b1;
        lat = 0;
        while (!cell_load && lat < 12) begin next_cycle(); lat++; end
        check("both_latency", lat, 7);
        check("both_no_ena_with_load", cell_ena, 0);
        next_cycle();
        check("both_gen_cleared", generation, 0);
        check("both_running", running, 1);
        check("both_load_single", cell_load, 0);

        // Wrap: 16 strobes from reload bring generation back to 0.
        n_ena = 0; n_load = 0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (i == 4) begin btn_run = 1'b0; btn_step = 1'b0; end
            if (cell_ena) begin
                n_ena++;
                if (generation == 4'd15) found = 1'b1;
            end
            n_load += int'(cell_load);
            if (!found) next_cycle();
        end
        check("wrap_found", found, 1);
        check("wrap_ena_count", n_ena, 16);
        check("wrap_no_reload", n_load, 0);
        next_cycle();
        check("wrap_gen_zero", generation, 0);

        // Pause, then reset during the STEP cycle.
        settle(4);
        btn_run = 1'b1;
        lat = 0;
        while (running && lat < 12) begin next_cycle(); lat++; end
        check("pause2_latency", lat, 7);
        btn_run = 1'b0;
        settle(10);
        btn_step = 1'b1;
        settle(7);
        rst = 1'b0; btn_step = 1'b0;
        #1;
        check("rst_step_no_ena", cell_ena, 0);
        check("rst_step_load", cell_load, 1);
        next_cycle();
        check("rst_after_no_ena", cell_ena, 0);
        check("rst_after_running", running, 0);
        rst = 1'b1;
        #1;
        check("rst_release_load", cell_load, 1);
        next_cycle();
        check("rst_release_running", running, 1);
        check("rst_release_gen", generation, 0);

`ifdef STALL_DETECT_EN
        hold_cells = 1'b1;
        k = 0;
        while (!cell_ena && k < 20) begin next_cycle(); k++; end
        check("stall_first_ena", cell_ena, 1);
        settle(2);
        check("stall_set", stalled, 1);
        check("stall_paused", running, 0);
        n_ena = 0;
        for (int i = 0; i < 12; i++) begin next_cycle(); n_ena += int'(cell_ena); end
        check("stall_no_ena", n_ena, 0);
        btn_run = 1'b1;
        lat = 0;
        while (!running && lat < 12) begin next_cycle(); lat++; end
        check("stall_resume", running, 1);
        check("stall_cleared", stalled, 0);
        btn_run = 1'b0;
`else
        k = 0;
        while (!cell_ena && k < 20) begin next_cycle(); k++; end
        settle(2);
        check("nostall_running", running, 1);
        check("nostall_flag", stalled, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, actual timeout required completion");
        $fatal(1);
    end
endmodule
